cache_controller: RTL

//  2-way set-associative, write-through, no-write-allocate data cache.

---
 rtl/cache_controller_if.sv | 37 +++
 rtl/cache_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cache_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller_if
//  Description : Pipeline-side and SRAM-side signal bundle of the data cache.
//                The cache uses the slave modport. The surrounding pipeline
//                and SRAM controller, or a testbench, use the master modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_controller_if;
    logic        rd_en_in;
    logic        wr_en_in;
    logic [31:0] address_in;
    logic [31:0] write_data_in;
    logic [31:0] read_data_out;
    logic        ready_out;
    logic        sram_rd_en_out;
    logic        sram_wr_en_out;
    logic [31:0] sram_address_out;
    logic [31:0] sram_write_data_out;
    logic [63:0] sram_read_data_in;
    logic        sram_ready_in;

    modport slave (
        input  rd_en_in, wr_en_in, address_in, write_data_in,
               sram_read_data_in, sram_ready_in,
        output read_data_out, ready_out, sram_rd_en_out, sram_wr_en_out,
               sram_address_out, sram_write_data_out
    );

    modport master (
        output rd_en_in, wr_en_in, address_in, write_data_in,
               sram_read_data_in, sram_ready_in,
        input  read_data_out, ready_out, sram_rd_en_out, sram_wr_en_out,
               sram_address_out, sram_write_data_out
    );
endinterface
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cache_controller
//  Description : 2-way set-associative, write-through, no-write-allocate data
//                cache between the MEM stage and the SRAM controller. Read
//                hits return data in the same cycle. Misses and all writes
//                hold ready_out low until the SRAM controller pulses ready.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_controller #(
    parameter int SET_W = 6,
    parameter int TAG_W = 10
) (
    input  wire logic            clk,
    input  wire logic            rst,     // asynchronous, active low
    cache_controller_if.slave    bus
);

    localparam int c_NUM_SETS = 1 << SET_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ_MISS = 2'd1,
        S_WRITE     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Line storage. Valid and LRU bits are reset. Tags and blocks are only
    // ever read through a valid bit, so they carry no reset.
    logic [c_NUM_SETS-1:0] r_valid [2];
    logic [c_NUM_SETS-1:0] r_lru;
    logic [TAG_W-1:0]      r_tag   [2][c_NUM_SETS];
    logic [63:0]           r_data  [2][c_NUM_SETS];

    logic [SET_W-1:0] w_index;
    logic [TAG_W-1:0] w_tag;
    logic             w_word;
    logic [1:0]       w_hit;
    logic             w_hit_any;
    logic             w_hit_way;
    logic [63:0]      w_hit_block;
    logic             w_victim;
    logic             w_is_write;
    logic             w_unused_addr_bits;

    assign w_index    = bus.address_in[SET_W+2:3];
    assign w_tag      = bus.address_in[TAG_W+SET_W+2:SET_W+3];
    assign w_word     = bus.address_in[2];
    assign w_is_write = bus.wr_en_in;   // a request with both enables set is a write

    // Byte offset within a word has no meaning for a word-wide cache
    assign w_unused_addr_bits = ^bus.address_in[1:0];

    // A set never holds two valid copies of one tag, so at most one way hits
    assign w_hit[0]    = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
    assign w_hit[1]    = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
    assign w_hit_any   = |w_hit;
    assign w_hit_way   = w_hit[1];
    assign w_hit_block = r_data[w_hit_way][w_index];

    // Fill goes to an empty way first, otherwise to the least-recently-used way
    assign w_victim = !r_valid[0][w_index] ? 1'b0 :
                      !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];

    // SRAM address and data are straight pass-throughs of the request
    assign bus.sram_address_out    = {bus.address_in[31:2], 2'b00};
    assign bus.sram_write_data_out = bus.write_data_in;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshake and SRAM strobes. An asserted reset forces the idle response.
    always_comb begin
        w_next_state       = r_state;
        bus.ready_out      = 1'b1;
        bus.read_data_out  = 32'd0;
        bus.sram_rd_en_out = 1'b0;
        bus.sram_wr_en_out = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_write) begin
                        bus.ready_out = 1'b0;
                        w_next_state  = S_WRITE;
                    end else if (bus.rd_en_in) begin
                        if (w_hit_any) begin
                            bus.read_data_out = w_word ? w_hit_block[63:32] : w_hit_block[31:0];
                        end else begin
                            bus.ready_out = 1'b0;
                            w_next_state  = S_READ_MISS;
                        end
                    end
                end
                S_READ_MISS: begin
                    bus.sram_rd_en_out = 1'b1;
                    bus.ready_out      = bus.sram_ready_in;
                    bus.read_data_out  = w_word ? bus.sram_read_data_in[63:32]
                                                : bus.sram_read_data_in[31:0];
                    if (bus.sram_ready_in) begin
                        w_next_state = S_IDLE;
                    end
                end
                S_WRITE: begin
                    bus.sram_wr_en_out = 1'b1;
                    bus.ready_out      = bus.sram_ready_in;
                    if (bus.sram_ready_in) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Valid and LRU bookkeeping: hits and fills make the touched way most-recently-used
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_lru      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rd_en_in && !w_is_write && w_hit_any) begin
                        r_lru[w_index] <= ~w_hit_way;
                    end
                end
                S_READ_MISS: begin
                    if (bus.sram_ready_in) begin
                        r_valid[w_victim][w_index] <= 1'b1;
                        r_lru[w_index]             <= ~w_victim;
                    end
                end
                S_WRITE: begin
                    if (bus.sram_ready_in && w_hit_any) begin
                        r_lru[w_index] <= ~w_hit_way;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and block contents: fill on read miss, merge a write hit into its word
    always_ff @(posedge clk) begin
        if (r_state == S_READ_MISS && bus.sram_ready_in) begin
            r_tag[w_victim][w_index]  <= w_tag;
            r_data[w_victim][w_index] <= bus.sram_read_data_in;
        end else if (r_state == S_WRITE && bus.sram_ready_in && w_hit_any) begin
            if (w_word) begin
                r_data[w_hit_way][w_index][63:32] <= bus.write_data_in;
            end else begin
                r_data[w_hit_way][w_index][31:0]  <= bus.write_data_in;
            end
        end
    end

endmodule
`default_nettype wire
